multicycle_control_fsm: RTL and testbench

Multi-cycle successor to the single-cycle MIPS ControlUnit, decoding the same opcode set (lw, sw, R-type, lui, xori, j, jal, beq, bne). Sequences each instruction through fetch/decode/execute/memory/writeback states and drives the shared-datapath control lines. Memory accesses use a req/ready handshake with a bounded-wait timeout. Illegal opcodes and bus timeouts trap. Sits between the instruction register and the multi-cycle datapath of the 32-bit MIPS processor.

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/multicycle_control_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state enum, opcodes,
// ALU operation selects and mux select constants.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_XOR   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUSRCB_RT      = 2'd0;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM     = 2'd2;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'd3;

    // Dispatch target out of DECODE; S_TRAP marks an unsupported opcode.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:    return S_MEM_ADDR;
            OP_RTYPE:        return S_R_EXEC;
            OP_LUI, OP_XORI: return S_I_EXEC;
            OP_BEQ, OP_BNE:  return S_BRANCH;
            OP_J, OP_JAL:    return S_JUMP;
            default:         return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts cycles a request waits on ready, flags expiry
// once MEM_TIMEOUT waits have elapsed and ready is still low.
module mem_wait_timer #(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_cyc,
    input  logic clear,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (wait_cyc) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // A ready arriving on the limit cycle drops wait_cyc, so completion wins.
    assign expired = (MEM_TIMEOUT != 0) && wait_cyc &&
                     (count == TIMEOUT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM with req/ready memory handshake and trap state.
// Optional CTRL_PERF_CNT_EN adds instr_count/wait_count performance counters.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                sign_extend,
    output logic                lui,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                jal,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [3:0]          state_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         instr_count,
    output logic [31:0]         wait_count
`endif
);

    state_t state, state_next;
    logic   set_illegal, set_buserr;
    logic   wait_cyc, timeout;

    // Outputs are forced low while reset is asserted so an aborted
    // instruction issues no writes in the reset cycle.
    assign mem_req  = rst_n && (state == S_FETCH || state == S_MEM_READ ||
                                state == S_MEM_WRITE);
    assign wait_cyc = mem_req && !mem_ready;
    assign state_o  = state;

    mem_wait_timer #(
        .TIMEOUT_W  (TIMEOUT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wait_cyc(wait_cyc),
        .clear   (state_next != state),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (set_illegal) illegal_op <= 1'b1;
            if (set_buserr)  bus_err    <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        set_illegal   = 1'b0;
        set_buserr    = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_RT;
        alu_op        = ALUOP_ADD;
        sign_extend   = 1'b0;
        lui           = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        jal           = 1'b0;
        instr_done    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    alu_src_b = ALUSRCB_FOUR;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end else if (timeout) begin
                        set_buserr = 1'b1;
                        state_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_b   = ALUSRCB_IMM_SH2;
                    sign_extend = 1'b1;
                    state_next  = decode_next(opcode);
                    set_illegal = (decode_next(opcode) == S_TRAP);
                end
                S_MEM_ADDR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = ALUSRCB_IMM;
                    sign_extend = 1'b1;
                    state_next  = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    i_or_d = 1'b1;
                    if (mem_ready) begin
                        state_next = S_MEM_WB;
                    end else if (timeout) begin
                        set_buserr = 1'b1;
                        state_next = S_TRAP;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_we = 1'b1;
                    i_or_d = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end else if (timeout) begin
                        set_buserr = 1'b1;
                        state_next = S_TRAP;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALUOP_FUNCT;
                    state_next = S_R_WB;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_I_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = ALUSRCB_IMM;
                    alu_op     = (opcode == OP_XORI) ? ALUOP_XOR : ALUOP_ADD;
                    lui        = (opcode == OP_LUI);
                    state_next = S_I_WB;
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    lui        = (opcode == OP_LUI);
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PCSRC_ALUOUT;
                    branch_ne     = (opcode == OP_BNE);
                    instr_done    = 1'b1;
                    state_next    = S_FETCH;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = PCSRC_JUMP;
                    reg_write  = (opcode == OP_JAL);
                    jal        = (opcode == OP_JAL);
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_TRAP:  state_next = S_TRAP;
                default: state_next = S_TRAP;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_count <= '0;
            wait_count  <= '0;
        end else begin
            if (instr_done) instr_count <= instr_count + 32'd1;
            if (wait_cyc)   wait_count  <= wait_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; perf-counter
// checks are compiled in when CTRL_PERF_CNT_EN is defined.
module tb_multicycle_control_fsm;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic       branch_ne, alu_src_a, sign_extend, lui, reg_dst, mem_to_reg;
    logic       reg_write, jal, instr_done, illegal_op, bus_err;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count, wait_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .OPCODE_W   (6),
        .TIMEOUT_W  (4),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .sign_extend(sign_extend),
        .lui(lui), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .jal(jal), .instr_done(instr_done),
        .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o)
`ifdef CTRL_PERF_CNT_EN
        , .instr_count(instr_count), .wait_count(wait_count)
`endif
    );

    // Holds reset over two edges and releases it just after a rising edge,
    // so the next falling edge is the first FETCH cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk); mem_ready = 1'b0; #1;
        n_tests++;
        if (state_o !== 4'(S_FETCH)) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", state_o, S_FETCH);
        end
        n_tests++;
        if ({mem_req, i_or_d, alu_src_a, alu_src_b, alu_op, pc_src} !== 9'b1_0_0_01_00_00) begin
            n_fail++; $display("FAIL reset_fetch_ctl: got %b want 100010000",
                {mem_req, i_or_d, alu_src_a, alu_src_b, alu_op, pc_src});
        end
        n_tests++;
        if ({ir_write, pc_write, reg_write, instr_done, illegal_op, bus_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_idle: got %b want 000000",
                {ir_write, pc_write, reg_write, instr_done, illegal_op, bus_err});
        end
    endtask

    task automatic test_lw();
        state_t exp_s [5] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB};
        int done_cnt = 0;
        do_reset();
        opcode = OP_LW;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            n_tests++;
            if (state_o !== 4'(exp_s[i])) begin
                n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]);
            end
            if (instr_done) done_cnt++;
            if (i == 0) begin
                n_tests++;
                if ({ir_write, pc_write} !== 2'b11) begin
                    n_fail++; $display("FAIL lw_fetch_wr: got %b want 11", {ir_write, pc_write});
                end
            end
            if (i == 1) begin
                n_tests++;
                if ({alu_src_b, sign_extend} !== 3'b11_1) begin
                    n_fail++; $display("FAIL lw_decode: got %b want 111", {alu_src_b, sign_extend});
                end
            end
            if (i == 3) begin
                n_tests++;
                if ({mem_req, i_or_d, mem_we} !== 3'b110) begin
                    n_fail++; $display("FAIL lw_memread: got %b want 110", {mem_req, i_or_d, mem_we});
                end
            end
            if (i == 4) begin
                n_tests++;
                if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
                    n_fail++; $display("FAIL lw_wb: got %b want 110", {reg_write, mem_to_reg, reg_dst});
                end
            end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_tests++;
        if (state_o !== 4'(S_FETCH)) begin
            n_fail++; $display("FAIL lw_return: got %0d want %0d", state_o, S_FETCH);
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL lw_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_sw_wait();
        state_t exp_s [7] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WRITE,
                              S_MEM_WRITE, S_MEM_WRITE, S_MEM_WRITE};
        logic   rdy   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        opcode = OP_SW;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); mem_ready = rdy[i]; #1;
            n_tests++;
            if (state_o !== 4'(exp_s[i])) begin
                n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_o, exp_s[i]);
            end
            if (i >= 3) begin
                n_tests++;
                if ({mem_req, mem_we, i_or_d, instr_done} !== {3'b111, (i == 6)}) begin
                    n_fail++; $display("FAIL sw_write[%0d]: got %b want %b", i,
                        {mem_req, mem_we, i_or_d, instr_done}, {3'b111, (i == 6)});
                end
            end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_tests++;
        if (state_o !== 4'(S_FETCH)) begin
            n_fail++; $display("FAIL sw_total_cycles: got %0d want %0d", state_o, S_FETCH);
        end
`ifdef CTRL_PERF_CNT_EN
        n_tests++;
        if ({instr_count, wait_count} !== {32'd1, 32'd3}) begin
            n_fail++; $display("FAIL sw_perf: got %0d/%0d want 1/3", instr_count, wait_count);
        end
`endif
    endtask

    task automatic test_branch_jump();
        logic [5:0] ops   [4] = '{OP_BNE, OP_BEQ, OP_JAL, OP_J};
        state_t     final_s [4] = '{S_BRANCH, S_BRANCH, S_JUMP, S_JUMP};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); mem_ready = 1'b1; #1;
                if (i == 2) begin
                    n_tests++;
                    if (state_o !== 4'(final_s[k])) begin
                        n_fail++; $display("FAIL bj_state[%0d]: got %0d want %0d", k, state_o, final_s[k]);
                    end
                end
            end
            n_tests++;
            case (k)
                0: if ({pc_write_cond, branch_ne, alu_op, pc_src, pc_write, instr_done} !== 8'b1_1_01_01_0_1) begin
                    n_fail++; $display("FAIL bne_ctl: got %b want 11010101",
                        {pc_write_cond, branch_ne, alu_op, pc_src, pc_write, instr_done});
                end
                1: if ({pc_write_cond, branch_ne, alu_op, alu_src_a} !== 5'b1_0_01_1) begin
                    n_fail++; $display("FAIL beq_ctl: got %b want 10011",
                        {pc_write_cond, branch_ne, alu_op, alu_src_a});
                end
                2: if ({pc_write, pc_src, reg_write, jal, instr_done} !== 6'b1_10_1_1_1) begin
                    n_fail++; $display("FAIL jal_ctl: got %b want 110111",
                        {pc_write, pc_src, reg_write, jal, instr_done});
                end
                default: if ({pc_write, pc_src, reg_write, jal, instr_done} !== 6'b1_10_0_0_1) begin
                    n_fail++; $display("FAIL j_ctl: got %b want 110001",
                        {pc_write, pc_src, reg_write, jal, instr_done});
                end
            endcase
        end
    endtask

    task automatic test_rtype_itype();
        do_reset();
        opcode = OP_RTYPE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            if (i == 2) begin
                n_tests++;
                if ({state_o, alu_src_a, alu_src_b, alu_op} !== {4'(S_R_EXEC), 5'b1_00_10}) begin
                    n_fail++; $display("FAIL rexec: got %b want %b",
                        {state_o, alu_src_a, alu_src_b, alu_op}, {4'(S_R_EXEC), 5'b1_00_10});
                end
            end
            if (i == 3) begin
                n_tests++;
                if ({reg_write, reg_dst, instr_done} !== 3'b111) begin
                    n_fail++; $display("FAIL rwb: got %b want 111", {reg_write, reg_dst, instr_done});
                end
            end
        end
        opcode = OP_XORI;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            if (i == 2) begin
                n_tests++;
                if ({state_o, alu_src_b, alu_op, sign_extend, lui} !== {4'(S_I_EXEC), 6'b10_11_0_0}) begin
                    n_fail++; $display("FAIL xori_exec: got %b want %b",
                        {state_o, alu_src_b, alu_op, sign_extend, lui}, {4'(S_I_EXEC), 6'b10_11_0_0});
                end
            end
        end
        opcode = OP_LUI;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            if (i == 2) begin
                n_tests++;
                if ({lui, alu_op, sign_extend} !== 4'b1_00_0) begin
                    n_fail++; $display("FAIL lui_exec: got %b want 1000", {lui, alu_op, sign_extend});
                end
            end
            if (i == 3) begin
                n_tests++;
                if ({state_o, reg_write, reg_dst, lui, instr_done} !== {4'(S_I_WB), 4'b1_0_1_1}) begin
                    n_fail++; $display("FAIL lui_wb: got %b want %b",
                        {state_o, reg_write, reg_dst, lui, instr_done}, {4'(S_I_WB), 4'b1011});
                end
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 6'b111111;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            n_tests++;
            if ({state_o, illegal_op, mem_req, instr_done, pc_write, bus_err} !== {4'(S_TRAP), 5'b10000}) begin
                n_fail++; $display("FAIL illegal_trap[%0d]: got %b want %b", i,
                    {state_o, illegal_op, mem_req, instr_done, pc_write, bus_err}, {4'(S_TRAP), 5'b10000});
            end
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        n_tests++;
        if ({state_o, illegal_op, mem_req} !== {4'(S_FETCH), 2'b01}) begin
            n_fail++; $display("FAIL illegal_recover: got %b want %b",
                {state_o, illegal_op, mem_req}, {4'(S_FETCH), 2'b01});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = OP_LW;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            n_tests++;
            if ({state_o, bus_err} !== {4'(S_FETCH), 1'b0}) begin
                n_fail++; $display("FAIL timeout_wait[%0d]: got %b want %b", i,
                    {state_o, bus_err}, {4'(S_FETCH), 1'b0});
            end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_tests++;
        if ({state_o, bus_err, mem_req, illegal_op} !== {4'(S_TRAP), 3'b100}) begin
            n_fail++; $display("FAIL timeout_trap: got %b want %b",
                {state_o, bus_err, mem_req, illegal_op}, {4'(S_TRAP), 3'b100});
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); mem_ready = (i == 15); #1;
            if (i == 15) begin
                n_tests++;
                if ({state_o, ir_write, pc_write} !== {4'(S_FETCH), 2'b11}) begin
                    n_fail++; $display("FAIL timeout_limit_ready: got %b want %b",
                        {state_o, ir_write, pc_write}, {4'(S_FETCH), 2'b11});
                end
            end
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        n_tests++;
        if ({state_o, bus_err} !== {4'(S_DECODE), 1'b0}) begin
            n_fail++; $display("FAIL timeout_no_err: got %b want %b",
                {state_o, bus_err}, {4'(S_DECODE), 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        opcode = OP_JAL;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
        end
        opcode = OP_LW;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
        end
        @(negedge clk); rst_n = 1'b0; #1;
        n_tests++;
        if ({state_o, reg_write, mem_to_reg, instr_done} !== {4'(S_MEM_WB), 3'b000}) begin
            n_fail++; $display("FAIL resetmid_abort: got %b want %b",
                {state_o, reg_write, mem_to_reg, instr_done}, {4'(S_MEM_WB), 3'b000});
        end
`ifdef CTRL_PERF_CNT_EN
        n_tests++;
        if (instr_count !== 32'd1) begin
            n_fail++; $display("FAIL resetmid_count_before: got %0d want 1", instr_count);
        end
`endif
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        n_tests++;
        if ({state_o, reg_write} !== {4'(S_FETCH), 1'b0}) begin
            n_fail++; $display("FAIL resetmid_fetch: got %b want %b",
                {state_o, reg_write}, {4'(S_FETCH), 1'b0});
        end
`ifdef CTRL_PERF_CNT_EN
        n_tests++;
        if ({instr_count, wait_count} !== 64'd0) begin
            n_fail++; $display("FAIL resetmid_count_after: got %0d/%0d want 0/0", instr_count, wait_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch_jump();
        test_rtype_itype();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
